// File: rtl/exe_stage_mul_if.sv
// ID/EXE -> EXE/MEM bus for the execute stage: decoded instruction, forwarding
// sources and memory-stage freeze in, registered *_EXE outputs and busy back.
interface exe_stage_mul_if;
  logic        pause;
  logic        in_valid;
  logic        WB_En_ID;
  logic [1:0]  MEM_Signal_ID;
  logic [3:0]  EXE_CMD_ID;
  logic [4:0]  dest_ID;
  logic        imm_ID;
  logic [31:0] val1_ID;
  logic [31:0] val2_ID;
  logic [31:0] reg2_ID;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [31:0] ALU_result_MEM;
  logic [31:0] wb_value;
  logic        busy;
  logic        WB_En_EXE;
  logic [1:0]  MEM_Signal_EXE;
  logic [4:0]  dest_EXE;
  logic [31:0] ALU_result_EXE;
  logic [31:0] reg2_EXE;

  modport master (
    output pause, in_valid, WB_En_ID, MEM_Signal_ID, EXE_CMD_ID, dest_ID, imm_ID,
           val1_ID, val2_ID, reg2_ID, fwd_sel1, fwd_sel2, ALU_result_MEM, wb_value,
    input  busy, WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE
  );

  modport slave (
    input  pause, in_valid, WB_En_ID, MEM_Signal_ID, EXE_CMD_ID, dest_ID, imm_ID,
           val1_ID, val2_ID, reg2_ID, fwd_sel1, fwd_sel2, ALU_result_MEM, wb_value,
    output busy, WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE
  );
endinterface

// File: rtl/exe_stage_mul.sv
// Execute stage + EXE/MEM register: operand forwarding, single-cycle ALU and, when
// EXE_MUL_EN is defined, an iterative MUL_BITS-per-cycle multiplier (otherwise MUL yields 0).
module exe_stage_mul #(
  parameter int MUL_BITS = 1
) (
  input logic            clk,
  input logic            rst,
  exe_stage_mul_if.slave bus
);
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              wb_en;
    logic [1:0]        mem_sig;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] reg2;
  } exe_reg_t;

  if (!(MUL_BITS == 1 || MUL_BITS == 2 || MUL_BITS == 4 || MUL_BITS == 8)) begin : g_bad_mul_bits
    $error("exe_stage_mul: MUL_BITS must be 1, 2, 4 or 8");
  end

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] mem,
                                                input logic [DATA_W-1:0] wb);
    case (sel)
      2'd1:    return mem;
      2'd2:    return wb;
      default: return rf;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] cmd,
                                            input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (cmd)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~(a | b);
      4'd5:    return a ^ b;
      4'd6:    return a << sh;
      4'd7:    return a >>> sh;
      4'd8:    return $unsigned(a) >> sh;
      default: return '0;
    endcase
  endfunction

  logic signed [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0]        store_data;
  exe_reg_t                 issue_p0, exe_q;

  // Stage p0: forwarding and ALU
  always_comb begin
    op_a       = fwd_mux(bus.fwd_sel1, bus.val1_ID, bus.ALU_result_MEM, bus.wb_value);
    op_b       = bus.imm_ID ? bus.val2_ID
                            : fwd_mux(bus.fwd_sel2, bus.val2_ID, bus.ALU_result_MEM, bus.wb_value);
    store_data = fwd_mux(bus.fwd_sel2, bus.reg2_ID, bus.ALU_result_MEM, bus.wb_value);
    issue_p0   = '0;
    if (bus.in_valid) begin
      issue_p0.wb_en   = bus.WB_En_ID;
      issue_p0.mem_sig = bus.MEM_Signal_ID;
      issue_p0.dest    = bus.dest_ID;
      issue_p0.result  = alu(bus.EXE_CMD_ID, op_a, op_b);
      issue_p0.reg2    = store_data;
    end
  end

  assign bus.WB_En_EXE      = exe_q.wb_en;
  assign bus.MEM_Signal_EXE = exe_q.mem_sig;
  assign bus.dest_EXE       = exe_q.dest;
  assign bus.ALU_result_EXE = exe_q.result;
  assign bus.reg2_EXE       = exe_q.reg2;

`ifdef EXE_MUL_EN
  localparam int         ITER    = DATA_W / MUL_BITS;
  localparam logic [3:0] CMD_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [5:0]        iter_cnt;
  logic              is_mul;
  logic [DATA_W-1:0] mcand_p1, mplier_p1, acc_p1, partial_p1;
  exe_reg_t          held_p1, done_p1;

  assign is_mul  = bus.in_valid && (bus.EXE_CMD_ID == CMD_MUL);
  // busy is raised as soon as a MUL is presented, even while the memory stage is frozen
  assign bus.busy = rst && ((state == RUN) || (state == IDLE && is_mul));

  always_comb begin
    partial_p1     = mcand_p1 * DATA_W'(mplier_p1[MUL_BITS-1:0]);
    done_p1        = held_p1;
    done_p1.result = acc_p1;
  end

  // Stage p1: shift-add multiplier; operands and control captured once at MUL start
  always_ff @(posedge clk) begin
    if (state == IDLE && is_mul && !bus.pause) begin
      mcand_p1  <= op_a;
      mplier_p1 <= op_b;
      acc_p1    <= '0;
      held_p1   <= issue_p0;
    end else if (state == RUN) begin
      acc_p1    <= acc_p1 + partial_p1;
      mcand_p1  <= mcand_p1 << MUL_BITS;
      mplier_p1 <= mplier_p1 >> MUL_BITS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
      exe_q    <= '0;
    end else begin
      case (state)
        IDLE: if (!bus.pause) begin
          if (is_mul) begin
            state    <= RUN;
            iter_cnt <= '0;
            exe_q    <= '0;
          end else begin
            exe_q <= issue_p0;
          end
        end
        RUN: begin
          iter_cnt <= iter_cnt + 6'd1;
          if (iter_cnt == 6'(ITER - 1)) state <= DONE;
          if (!bus.pause) exe_q <= '0;
        end
        DONE: if (!bus.pause) begin
          exe_q <= done_p1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign bus.busy = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            exe_q <= '0;
    else if (!bus.pause) exe_q <= issue_p0;
  end
`endif
endmodule

// File: tb/tb_exe_stage_mul.sv
// Self-checking bench for exe_stage_mul: directed cases plus randomized traffic
// checked every cycle against a behavioural model (MUL behaviour follows EXE_MUL_EN).
module tb_exe_stage_mul;
  localparam int MUL_BITS = 1;
  localparam int N_ITER   = 32 / MUL_BITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  exe_stage_mul_if bus ();
  exe_stage_mul #(.MUL_BITS(MUL_BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, {40'd0, act}, {40'd0, exp});
  endtask

  function automatic logic [71:0] dut_outs();
    return {bus.WB_En_EXE, bus.MEM_Signal_EXE, bus.dest_EXE, bus.ALU_result_EXE, bus.reg2_EXE};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    case (cmd)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ~(a | b);
      4'd5: return a ^ b;
      4'd6: return a << sh;
      4'd7: begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      4'd8: return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  logic [71:0] exp_out    = '0;
  logic [71:0] mul_out    = '0;
  int          mul_phase  = 0;  // 0 none, 1 iterating, 2 product waiting for an unpaused edge
  int          iters_left = 0;

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] a, b, r2;
    logic [63:0] prod;
    if (!rst) begin
      exp_out    = '0;
      mul_phase  = 0;
      iters_left = 0;
    end else begin
      a  = pick(bus.fwd_sel1, bus.val1_ID, bus.ALU_result_MEM, bus.wb_value);
      b  = bus.imm_ID ? bus.val2_ID : pick(bus.fwd_sel2, bus.val2_ID, bus.ALU_result_MEM, bus.wb_value);
      r2 = pick(bus.fwd_sel2, bus.reg2_ID, bus.ALU_result_MEM, bus.wb_value);
`ifdef EXE_MUL_EN
      if (mul_phase == 1) begin
        iters_left--;
        if (iters_left == 0) mul_phase = 2;
        if (!bus.pause) exp_out = '0;
      end else if (mul_phase == 2) begin
        if (!bus.pause) begin
          exp_out   = mul_out;
          mul_phase = 0;
        end
      end else if (!bus.pause) begin
        if (bus.in_valid && bus.EXE_CMD_ID == 4'd9) begin
          prod       = {32'd0, a} * {32'd0, b};
          mul_out    = {bus.WB_En_ID, bus.MEM_Signal_ID, bus.dest_ID, prod[31:0], r2};
          mul_phase  = 1;
          iters_left = N_ITER;
          exp_out    = '0;
        end else begin
          exp_out = bus.in_valid ? {bus.WB_En_ID, bus.MEM_Signal_ID, bus.dest_ID,
                                    ref_alu(bus.EXE_CMD_ID, a, b), r2} : '0;
        end
      end
`else
      if (!bus.pause)
        exp_out = bus.in_valid ? {bus.WB_En_ID, bus.MEM_Signal_ID, bus.dest_ID,
                                  ref_alu(bus.EXE_CMD_ID, a, b), r2} : '0;
`endif
    end
  end

  always @(negedge clk) begin : compare
    logic exp_busy;
`ifdef EXE_MUL_EN
    exp_busy = rst && (mul_phase == 1 ||
                       (mul_phase == 0 && bus.in_valid && bus.EXE_CMD_ID == 4'd9));
`else
    exp_busy = 1'b0;
`endif
    check("exe_regs", dut_outs(), exp_out);
    check("busy", {71'd0, bus.busy}, {71'd0, exp_busy});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pause = 1'b0;          bus.in_valid = 1'b0;      bus.WB_En_ID = 1'b0;
    bus.MEM_Signal_ID = 2'd0;  bus.EXE_CMD_ID = 4'd0;    bus.dest_ID = 5'd0;
    bus.imm_ID = 1'b0;         bus.val1_ID = 32'd0;      bus.val2_ID = 32'd0;
    bus.reg2_ID = 32'd0;       bus.fwd_sel1 = 2'd0;      bus.fwd_sel2 = 2'd0;
    bus.ALU_result_MEM = 32'd0; bus.wb_value = 32'd0;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] dest);
    bus.in_valid = 1'b1;  bus.WB_En_ID = 1'b1;  bus.MEM_Signal_ID = 2'd0;
    bus.EXE_CMD_ID = cmd; bus.dest_ID = dest;   bus.imm_ID = 1'b0;
    bus.val1_ID = v1;     bus.val2_ID = v2;     bus.reg2_ID = 32'd0;
    bus.fwd_sel1 = 2'd0;  bus.fwd_sel2 = 2'd0;
  endtask

`ifdef EXE_MUL_EN
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
    issue(4'd9, 32'h0, b, 5'd9);
    bus.fwd_sel1 = 2'd1;
    bus.ALU_result_MEM = a;
    #1;
    check32({name, "_busy_c0"}, {31'd0, bus.busy}, 32'd1);
    for (int c = 1; c <= N_ITER + 1; c++) begin
      tick();
      if (c == N_ITER)     check32({name, "_busy_last"}, {31'd0, bus.busy}, 32'd1);
      if (c == N_ITER + 1) check32({name, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
      bus.ALU_result_MEM = $urandom();
      bus.wb_value       = $urandom();
      if (c == N_ITER + 1) bus.in_valid = 1'b0;
    end
    tick();
    check32(name, bus.ALU_result_EXE, expv);
  endtask
`endif

  initial begin
    logic        hold;
    logic [31:0] r;
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    check("reset_regs", dut_outs(), 72'd0);
    check32("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;

    issue(4'd0, 32'd5, 32'd7, 5'd3);
    tick();
    check32("add_result", bus.ALU_result_EXE, 32'd12);
    check32("add_ctrl", {26'd0, bus.WB_En_EXE, bus.dest_EXE}, {26'd0, 1'b1, 5'd3});

    issue(4'd1, 32'hDEAD, 32'd1, 5'd4);
    bus.fwd_sel1 = 2'd1; bus.ALU_result_MEM = 32'd100;
    tick();
    check32("sub_fwd_mem", bus.ALU_result_EXE, 32'd99);

    issue(4'd0, 32'h1000, 32'd4, 5'd0);
    bus.WB_En_ID = 1'b0; bus.MEM_Signal_ID = 2'b01; bus.imm_ID = 1'b1;
    bus.fwd_sel2 = 2'd2; bus.reg2_ID = 32'h11; bus.wb_value = 32'hAB;
    tick();
    check32("store_fwd_wb", bus.reg2_EXE, 32'hAB);
    check32("store_addr", bus.ALU_result_EXE, 32'h1004);
    check32("store_ctrl", {29'd0, bus.WB_En_EXE, bus.MEM_Signal_EXE}, {29'd0, 1'b0, 2'b01});

    issue(4'd7, 32'h8000_0000, 32'd4, 5'd6);
    tick();
    check32("sra", bus.ALU_result_EXE, 32'hF800_0000);
    issue(4'd8, 32'h8000_0000, 32'd4, 5'd6);
    tick();
    check32("srl", bus.ALU_result_EXE, 32'h0800_0000);
    issue(4'd4, 32'h0F0F_0000, 32'h0000_00FF, 5'd7);
    tick();
    check32("nor", bus.ALU_result_EXE, 32'hF0F0_FF00);

    bus.in_valid = 1'b0;
    tick();
    check("bubble", dut_outs(), 72'd0);

    issue(4'd0, 32'd1, 32'd2, 5'd8);
    tick();
    issue(4'd5, 32'hFFFF, 32'h1, 5'd9);
    bus.pause = 1'b1;
    repeat (2) tick();
    check32("pause_hold", bus.ALU_result_EXE, 32'd3);
    bus.pause = 1'b0;
    tick();
    check32("pause_release", bus.ALU_result_EXE, 32'hFFFE);
    bus.in_valid = 1'b0;
    tick();

`ifdef EXE_MUL_EN
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42);
    run_mul("mul_wrap", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);

    issue(4'd9, 32'd3, 32'd5, 5'd10);
    repeat (10) tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.ALU_result_MEM = $urandom();
      bus.wb_value       = $urandom();
    end
    check32("mul_paused_frozen", bus.ALU_result_EXE, 32'd0);
    check32("mul_paused_done_busy", {31'd0, bus.busy}, 32'd0);
    bus.pause = 1'b0;
    tick();
    check32("mul_after_pause", bus.ALU_result_EXE, 32'd15);
    check32("mul_after_pause_dest", {27'd0, bus.dest_EXE}, 32'd10);
    bus.in_valid = 1'b0;
    tick();
`else
    issue(4'd9, 32'd7, 32'd6, 5'd9);
    tick();
    check32("mul_disabled", bus.ALU_result_EXE, 32'd0);
    check32("mul_disabled_busy", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = 1'b0;
    tick();
`endif

    issue(4'd0, 32'd40, 32'd2, 5'd11);
    tick();
    issue(4'd9, 32'd100, 32'd3, 5'd11);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_regs", dut_outs(), 72'd0);
    check32("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    issue(4'd0, 32'd1, 32'd1, 5'd12);
    tick();
    check32("add_after_rst", bus.ALU_result_EXE, 32'd2);
    bus.in_valid = 1'b0;
    tick();

    hold = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!hold) begin
        r = $urandom();
        bus.in_valid      = (r[2:0] != 3'd0);
        bus.WB_En_ID      = r[3];
        bus.MEM_Signal_ID = r[5:4];
        bus.imm_ID        = r[6];
        bus.fwd_sel1      = r[8:7];
        bus.fwd_sel2      = r[10:9];
        bus.dest_ID       = r[15:11];
        bus.EXE_CMD_ID    = (r[19:16] == 4'd0) ? 4'd9 : r[23:20];
        bus.val1_ID       = $urandom();
        bus.val2_ID       = (r[25:24] == 2'd0) ? 32'($urandom_range(0, 40)) : $urandom();
        bus.reg2_ID       = $urandom();
      end
      bus.ALU_result_MEM = $urandom();
      bus.wb_value       = $urandom();
      bus.pause          = ($urandom_range(0, 9) == 0);
      #1;
      hold = bus.busy || bus.pause;
      tick();
    end
    idle_inputs();
    repeat (N_ITER + 4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
